joy_input_conditioner: RTL and testbench
========================================

// Module: joy_input_conditioner
// PURPOSE
//  Sits directly downstream of the SPI joystick receiver in the game clock domain. Its inputs are
//  the receiver's JOY0/JOY1/BUTTONS/SWITCHES outputs, which are asynchronous to CLK. It produces
//  clean, synchronous, active-high Phoenix cabinet controls, which feed the game's input port mux.
//  It synchronises and debounces every input, resolves left/right conflicts, adds optional
//  autofire, and turns the coin button into a fixed-length coin pulse.
// PARAMETERS
//  DB_MAX   default 1000    cycles an input must stay stable before its debounced value changes (>=2)
//  AF_HALF  default 100000  autofire half-period in CLK cycles (>=1)
//  COIN_LEN default 50000   COIN pulse length in CLK cycles (>=1)
// PORTS
//  CLK        in   1  game clock; all logic on posedge
//  RESET      in   1  synchronous, active-high reset
//  JOY0       in   6  player 1 joystick: [0]right [1]left [2]down [3]up [4]fire1 [5]fire2 (async)
//  JOY1       in   6  player 2 joystick, same bit map (async)
//  BUTTONS    in   2  [0] coin, [1] start (async)
//  SWITCHES   in   2  [0] autofire enable, [1] two-player select (async)
//  P1_LEFT    out  1  player 1 move left
//  P1_RIGHT   out  1  player 1 move right
//  P1_FIRE    out  1  player 1 fire
//  P1_BARRIER out  1  player 1 barrier (shield)
//  P2_LEFT    out  1  player 2 move left
//  P2_RIGHT   out  1  player 2 move right
//  P2_FIRE    out  1  player 2 fire
//  P2_BARRIER out  1  player 2 barrier (shield)
//  COIN       out  1  coin pulse, exactly COIN_LEN cycles long
//  START1     out  1  one-player start
//  START2     out  1  two-player start
// BEHAVIOUR
//  - Sync: all 16 input bits pass through a 2-FF synchroniser (s1->s2). Reset value is 0.
//  - Debounce: the 14 JOY/BUTTONS bits each have a debounced register db and a counter cnt.
//      Counter width is $clog2(DB_MAX).
//      * If s2 == db: cnt <= 0.
//      * Else if cnt == DB_MAX-1: db <= s2 and cnt <= 0.
//      * Else: cnt <= cnt+1.
//    SWITCHES are synchronised only, not debounced.
//  - Latency: an input stable from sampling edge 0 onward changes db at edge DB_MAX+1.
//    A glitch shorter than DB_MAX cycles never reaches db.
//  - Left/right (per player): LEFT = dbL & ~dbR; RIGHT = dbR & ~dbL. Both pressed -> both 0.
//    Up/down are ignored.
//  - BARRIER = db fire2. It is never autofired.
//  - Fire (per player, independent autofire counter and phase):
//      * SWITCHES sync[0] = 0: FIRE = db fire1.
//      * SWITCHES sync[0] = 1 while db fire1 = 1: FIRE is 1 for AF_HALF cycles, then 0 for
//        AF_HALF cycles, repeating. The first high phase starts in the cycle db fire1 rises.
//      * db fire1 = 0: FIRE = 0 and the counter/phase are held at reset state. A new press
//        always starts with a full high phase.
//      * Toggling the autofire enable mid-press takes effect in the next cycle.
//  - Coin FSM:
//      * States: ARM_WAIT -> IDLE -> PULSE -> IDLE.
//      * Reset enters ARM_WAIT. ARM_WAIT goes to IDLE once db coin == 0, so a button held
//        through reset never produces a coin.
//      * IDLE: a rising edge of db coin enters PULSE. COIN = 1 for exactly COIN_LEN cycles,
//        then IDLE.
//      * Coin edges during PULSE are ignored (no retrigger, no queueing).
//      * COIN is registered: high in the cycle after the db rising edge.
//  - Start:
//      * SWITCHES sync[1] = 0: START1 = db start, START2 = 0.
//      * SWITCHES sync[1] = 1: START2 = db start, START1 = 0.
//  - All outputs are registered. Outputs other than COIN add 1 cycle after db/phase.
//  - Reset: all outputs 0; all sync/db/cnt/autofire state 0. RESET during PULSE drops COIN
//    the next cycle, and the FSM goes to ARM_WAIT.
//  - Counters saturate or clear as above and never wrap. The autofire counter wraps only at
//    AF_HALF boundaries, toggling the phase.
// TESTING
//  - Hold JOY0[1]=1 from edge 0 (DB_MAX=4) -> P1_LEFT=1 from cycle DB_MAX+2.
//    A 3-cycle pulse on JOY0[0] -> P1_RIGHT never rises.
//  - JOY1[1:0]=2'b11 held -> P2_LEFT=P2_RIGHT=0.
//    Release bit0 -> P2_LEFT=1 after debounce latency.
//  - SWITCHES=2'b01, AF_HALF=3, hold JOY0[4] -> P1_FIRE pattern 111000111000...
//    Release -> 0. Re-press -> the pattern restarts with 111.
//  - COIN_LEN=5: press BUTTONS[0] for 20 cycles -> COIN high exactly 5 cycles, once.
//    A second press during the pulse produces no extra cycles.
//  - BUTTONS[0]=1 held across RESET -> no COIN pulse.
//    Release, then press -> one pulse. Assert RESET mid-pulse -> COIN=0 the next cycle.
//  - BUTTONS[1]=1 with SWITCHES[1]=0 -> START1=1, START2=0.
//    Flip SWITCHES[1] to 1 -> START2=1 and START1=0 within 4 cycles.

Source files
------------

// File: rtl/joy_input_conditioner.sv
// joy_input_conditioner
//   Turns the asynchronous joystick/button/switch outputs of the SPI joystick receiver into clean,
//   synchronous, active-high Phoenix cabinet controls in the game clock domain.
//   Every input is 2-FF synchronised. Joystick and button bits are also debounced.
//   Left/right conflicts resolve to "neither". Fire has optional per-player autofire.
//   The coin button produces one fixed-length COIN pulse per press.
//
// Parameters
//   DB_MAX   : cycles an input must stay stable before its debounced value changes (>= 2)
//   AF_HALF  : autofire half-period in CLK cycles (>= 1)
//   COIN_LEN : COIN pulse length in CLK cycles (>= 1)
//
// Ports
//   CLK                    in   game clock, posedge
//   RESET                  in   synchronous, active-high reset
//   JOY0 / JOY1 [5:0]      in   [0]right [1]left [2]down [3]up [4]fire1 [5]fire2 (async)
//   BUTTONS [1:0]          in   [0]coin [1]start (async)
//   SWITCHES [1:0]         in   [0]autofire enable [1]two-player select (async)
//   P1_/P2_ LEFT, RIGHT, FIRE, BARRIER      out  registered player controls
//   COIN                   out  registered coin pulse, COIN_LEN cycles
//   START1 / START2        out  registered start controls

module joy_input_conditioner #(
  parameter int unsigned DB_MAX   = 1000,
  parameter int unsigned AF_HALF  = 100000,
  parameter int unsigned COIN_LEN = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] JOY0,
  input  logic [5:0] JOY1,
  input  logic [1:0] BUTTONS,
  input  logic [1:0] SWITCHES,
  output logic       P1_LEFT,
  output logic       P1_RIGHT,
  output logic       P1_FIRE,
  output logic       P1_BARRIER,
  output logic       P2_LEFT,
  output logic       P2_RIGHT,
  output logic       P2_FIRE,
  output logic       P2_BARRIER,
  output logic       COIN,
  output logic       START1,
  output logic       START2
);

  localparam int unsigned DbW   = $clog2(DB_MAX);
  localparam int unsigned AfW   = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
  localparam int unsigned CoinW = (COIN_LEN > 1) ? $clog2(COIN_LEN) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_MAX - 1);
  localparam logic [AfW-1:0]   AfLast   = AfW'(AF_HALF - 1);
  localparam logic [CoinW-1:0] CoinLast = CoinW'(COIN_LEN - 1);

  // Bit positions in the packed input vector {SWITCHES, BUTTONS, JOY1, JOY0}
  localparam int unsigned BitP1Right = 0;
  localparam int unsigned BitP1Left  = 1;
  localparam int unsigned BitP1Fire1 = 4;
  localparam int unsigned BitP1Fire2 = 5;
  localparam int unsigned BitP2Right = 6;
  localparam int unsigned BitP2Left  = 7;
  localparam int unsigned BitP2Fire1 = 10;
  localparam int unsigned BitP2Fire2 = 11;
  localparam int unsigned BitCoin    = 12;
  localparam int unsigned BitStart   = 13;
  localparam int unsigned BitAutoEn  = 14;
  localparam int unsigned BitTwoPl   = 15;

  typedef enum logic [1:0] {
    StArmWait,
    StIdle,
    StPulse
  } coin_state_e;

  logic [15:0]    w_raw;
  logic [15:0]    r_s1;
  logic [15:0]    r_s2;
  logic [13:0]    r_db;
  logic [DbW-1:0] r_cnt [14];

  logic [1:0]     w_fire1;
  logic [1:0]     w_fire;
  logic [AfW-1:0] r_af_cnt [2];
  logic [1:0]     r_af_phase;   // 0 = high phase, 1 = low phase

  coin_state_e      r_coin_state;
  logic [CoinW-1:0] r_coin_cnt;
  logic             r_coin_prev;
  logic [1:0]       r_fill;
  logic             r_coin;

  logic r_p1_left, r_p1_right, r_p1_fire, r_p1_barrier;
  logic r_p2_left, r_p2_right, r_p2_fire, r_p2_barrier;
  logic r_start1, r_start2;

  logic w_unused_updown;

  assign w_raw = {SWITCHES, BUTTONS, JOY1, JOY0};

  // Up/down are debounced with the rest but drive nothing.
  assign w_unused_updown = ^{r_db[9:8], r_db[3:2]};

  // Synchroniser and per-bit debounce
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_db <= '0;
      for (int i = 0; i < 14; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 14; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DbLast) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    w_fire1 = {r_db[BitP2Fire1], r_db[BitP1Fire1]};
    w_fire  = '0;
    for (int p = 0; p < 2; p++) begin
      w_fire[p] = w_fire1[p] & (~r_s2[BitAutoEn] | ~r_af_phase[p]);
    end
  end

  // Autofire timers run only while fire1 is held, so each press starts with a full high phase.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_af_phase <= '0;
      for (int p = 0; p < 2; p++) begin
        r_af_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (!w_fire1[p]) begin
          r_af_cnt[p]   <= '0;
          r_af_phase[p] <= 1'b0;
        end else if (r_af_cnt[p] == AfLast) begin
          r_af_cnt[p]   <= '0;
          r_af_phase[p] <= ~r_af_phase[p];
        end else begin
          r_af_cnt[p] <= r_af_cnt[p] + AfW'(1);
        end
      end
    end
  end

  // Coin FSM. Reset clears the debouncer, so a button held through reset would look like a fresh
  // press; ARM_WAIT therefore also waits for the refilled synchroniser to show the button low.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_coin_state <= StArmWait;
      r_coin_cnt   <= '0;
      r_coin_prev  <= 1'b0;
      r_fill       <= '0;
      r_coin       <= 1'b0;
    end else begin
      r_coin_prev <= r_db[BitCoin];
      r_fill      <= {r_fill[0], 1'b1};
      unique case (r_coin_state)
        StArmWait: begin
          r_coin <= 1'b0;
          if (r_fill[1] && !r_s2[BitCoin] && !r_db[BitCoin]) begin
            r_coin_state <= StIdle;
          end
        end
        StIdle: begin
          if (r_db[BitCoin] && !r_coin_prev) begin
            r_coin_state <= StPulse;
            r_coin_cnt   <= '0;
            r_coin       <= 1'b1;
          end
        end
        StPulse: begin
          if (r_coin_cnt == CoinLast) begin
            r_coin_state <= StIdle;
            r_coin_cnt   <= '0;
            r_coin       <= 1'b0;
          end else begin
            r_coin_cnt <= r_coin_cnt + CoinW'(1);
          end
        end
        default: begin
          r_coin_state <= StArmWait;
          r_coin       <= 1'b0;
        end
      endcase
    end
  end

  // Registered player and start outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_p1_left    <= 1'b0;
      r_p1_right   <= 1'b0;
      r_p1_fire    <= 1'b0;
      r_p1_barrier <= 1'b0;
      r_p2_left    <= 1'b0;
      r_p2_right   <= 1'b0;
      r_p2_fire    <= 1'b0;
      r_p2_barrier <= 1'b0;
      r_start1     <= 1'b0;
      r_start2     <= 1'b0;
    end else begin
      r_p1_left    <= r_db[BitP1Left] & ~r_db[BitP1Right];
      r_p1_right   <= r_db[BitP1Right] & ~r_db[BitP1Left];
      r_p1_fire    <= w_fire[0];
      r_p1_barrier <= r_db[BitP1Fire2];
      r_p2_left    <= r_db[BitP2Left] & ~r_db[BitP2Right];
      r_p2_right   <= r_db[BitP2Right] & ~r_db[BitP2Left];
      r_p2_fire    <= w_fire[1];
      r_p2_barrier <= r_db[BitP2Fire2];
      r_start1     <= r_db[BitStart] & ~r_s2[BitTwoPl];
      r_start2     <= r_db[BitStart] & r_s2[BitTwoPl];
    end
  end

  assign P1_LEFT    = r_p1_left;
  assign P1_RIGHT   = r_p1_right;
  assign P1_FIRE    = r_p1_fire;
  assign P1_BARRIER = r_p1_barrier;
  assign P2_LEFT    = r_p2_left;
  assign P2_RIGHT   = r_p2_right;
  assign P2_FIRE    = r_p2_fire;
  assign P2_BARRIER = r_p2_barrier;
  assign COIN       = r_coin;
  assign START1     = r_start1;
  assign START2     = r_start2;

endmodule

// File: tb/tb_joy_input_conditioner.sv
// Testbench for joy_input_conditioner: directed scenarios plus randomized input segments, every
// cycle compared against a behavioural model of the conditioner.

module tb_joy_input_conditioner;

  localparam int DbMax   = 4;
  localparam int AfHalf  = 3;
  localparam int CoinLen = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] joy0 = '0;
  logic [5:0] joy1 = '0;
  logic [1:0] buttons = '0;
  logic [1:0] switches = '0;

  logic p1_left, p1_right, p1_fire, p1_barrier;
  logic p2_left, p2_right, p2_fire, p2_barrier;
  logic coin, start1, start2;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned hi_coin = 0;
  int unsigned hi_p1r  = 0;

  // Model state: values of the corresponding quantities in the current cycle
  logic [15:0] m_s1, m_s2;
  logic [13:0] m_db, m_db_prev;
  logic [13:0] m_hist[$];     // last DbMax synchronised samples
  int          m_cyc = 0;
  int          m_start[2];    // cycle in which each player's fire1 press began
  int          m_since;       // edges since reset
  bit          m_armed;
  int          m_left;        // remaining COIN-high cycles
  logic [10:0] m_out;

  joy_input_conditioner #(
    .DB_MAX  (DbMax),
    .AF_HALF (AfHalf),
    .COIN_LEN(CoinLen)
  ) u_dut (
    .CLK       (clk),
    .RESET     (rst),
    .JOY0      (joy0),
    .JOY1      (joy1),
    .BUTTONS   (buttons),
    .SWITCHES  (switches),
    .P1_LEFT   (p1_left),
    .P1_RIGHT  (p1_right),
    .P1_FIRE   (p1_fire),
    .P1_BARRIER(p1_barrier),
    .P2_LEFT   (p2_left),
    .P2_RIGHT  (p2_right),
    .P2_FIRE   (p2_fire),
    .P2_BARRIER(p2_barrier),
    .COIN      (coin),
    .START1    (start1),
    .START2    (start2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] outs();
    return {p1_left, p1_right, p1_fire, p1_barrier,
            p2_left, p2_right, p2_fire, p2_barrier, coin, start1, start2};
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [15:0] in_v;
    logic [13:0] nd;
    logic [10:0] o;
    int          fb;
    bit          hi;
    bit          flip;
    in_v = {switches, buttons, joy1, joy0};
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_db_prev = '0;
      m_hist.delete();
      m_since = 0; m_armed = 0; m_left = 0; m_out = '0;
      m_start[0] = 0; m_start[1] = 0;
    end else begin
      o = '0;
      o[10] = m_db[1] & ~m_db[0];
      o[9]  = m_db[0] & ~m_db[1];
      o[7]  = m_db[5];
      o[6]  = m_db[7] & ~m_db[6];
      o[5]  = m_db[6] & ~m_db[7];
      o[3]  = m_db[11];
      for (int p = 0; p < 2; p++) begin
        fb = (p == 0) ? 4 : 10;
        hi = (((m_cyc - m_start[p]) / AfHalf) % 2) == 0;
        o[(p == 0) ? 8 : 4] = m_db[fb] && (!m_s2[14] || hi);
      end
      o[1] = m_db[13] & ~m_s2[15];
      o[0] = m_db[13] & m_s2[15];
      // Coin: arm once the button is seen low, then one COIN_LEN pulse per debounced rise
      if (!m_armed) begin
        if (m_since >= 2 && !m_s2[12] && !m_db[12]) m_armed = 1;
      end else if (m_left > 0) begin
        m_left--;
      end else if (m_db[12] && !m_db_prev[12]) begin
        m_left = CoinLen;
      end
      o[2] = (m_left > 0);
      // Debounce: a bit flips once its last DbMax samples all disagree with it
      m_hist.push_back(m_s2[13:0]);
      if (m_hist.size() > DbMax) void'(m_hist.pop_front());
      nd = m_db;
      for (int b = 0; b < 14; b++) begin
        flip = (m_hist.size() == DbMax);
        foreach (m_hist[k]) if (m_hist[k][b] == m_db[b]) flip = 0;
        if (flip) nd[b] = ~m_db[b];
      end
      if (nd[4] && !m_db[4]) m_start[0] = m_cyc + 1;
      if (nd[10] && !m_db[10]) m_start[1] = m_cyc + 1;
      m_db_prev = m_db;
      m_db      = nd;
      m_s2      = m_s1;
      m_s1      = in_v;
      if (m_since < 1000) m_since++;
      m_out = o;
    end
    m_cyc++;
  endtask

  task automatic step();
    logic [10:0] g;
    @(posedge clk);
    model_edge();
    #1;
    g = outs();
    check_eq("p1", 32'(g[10:7]), 32'(m_out[10:7]));
    check_eq("p2", 32'(g[6:3]), 32'(m_out[6:3]));
    check_eq("coin", 32'(g[2]), 32'(m_out[2]));
    check_eq("start", 32'(g[1:0]), 32'(m_out[1:0]));
    hi_coin += 32'(g[2]);
    hi_p1r  += 32'(g[9]);
  endtask

  // Wait (bounded) for P1_FIRE to rise, then expect the 3-high/3-low autofire pattern.
  task automatic af_pattern(input string tag);
    bit          seen;
    logic [11:0] pat;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = p1_fire;
    end
    check_eq({tag, "_rise"}, 32'(seen), 32'd1);
    pat = '0;
    pat[11] = p1_fire;
    for (int i = 10; i >= 0; i--) begin
      step();
      pat[i] = p1_fire;
    end
    check_eq({tag, "_pat"}, 32'(pat), 32'hE38);
  endtask

  initial begin
    int hold;
    bit seen;

    rst = 1'b1;
    step();
    step();
    check_eq("rst_outs", 32'(outs()), 32'd0);

    // Held left, short right glitch
    rst  = 1'b0;
    joy0 = 6'b000010;
    repeat (8) step();
    check_eq("p1_left_held", 32'(p1_left), 32'd1);
    hi_p1r = 0;
    joy0[0] = 1'b1;
    repeat (3) step();
    joy0[0] = 1'b0;
    repeat (8) step();
    check_eq("glitch_right", hi_p1r, 32'd0);

    // Player 2 conflict
    joy1 = 6'b000011;
    repeat (10) step();
    check_eq("p2_conflict", 32'({p2_left, p2_right}), 32'd0);
    joy1 = 6'b000010;
    repeat (8) step();
    check_eq("p2_left_rel", 32'(p2_left), 32'd1);

    // Autofire
    joy0     = 6'b000000;
    joy1     = 6'b000000;
    repeat (8) step();
    switches = 2'b01;
    joy0     = 6'b010000;
    af_pattern("af1");
    joy0 = 6'b000000;
    repeat (8) step();
    check_eq("af_release", 32'(p1_fire), 32'd0);
    joy0 = 6'b010000;
    af_pattern("af2");
    joy0     = 6'b000000;
    switches = 2'b00;
    repeat (8) step();

    // Coin: one pulse of CoinLen cycles for a 20-cycle press
    hi_coin = 0;
    buttons = 2'b01;
    repeat (20) step();
    buttons = 2'b00;
    repeat (10) step();
    check_eq("coin_len", hi_coin, 32'(CoinLen));

    // Coin held through reset gives nothing
    buttons = 2'b01;
    repeat (12) step();
    rst = 1'b1;
    repeat (3) step();
    rst     = 1'b0;
    hi_coin = 0;
    repeat (30) step();
    check_eq("coin_held_rst", hi_coin, 32'd0);
    buttons = 2'b00;
    repeat (10) step();
    buttons = 2'b01;
    hi_coin = 0;
    repeat (20) step();
    check_eq("coin_after_rel", hi_coin, 32'(CoinLen));

    // Reset mid-pulse
    buttons = 2'b00;
    repeat (10) step();
    buttons = 2'b01;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = coin;
    end
    check_eq("coin_rise", 32'(seen), 32'd1);
    step();
    rst = 1'b1;
    step();
    check_eq("coin_rst_drop", 32'(coin), 32'd0);
    rst     = 1'b0;
    buttons = 2'b00;
    repeat (10) step();

    // Start routing
    switches = 2'b00;
    buttons  = 2'b10;
    repeat (8) step();
    check_eq("start_1p", 32'({start1, start2}), 32'b10);
    switches = 2'b10;
    repeat (4) step();
    check_eq("start_2p", 32'({start1, start2}), 32'b01);
    buttons  = 2'b00;
    switches = 2'b00;
    repeat (8) step();

    // Randomized segments
    for (int seg = 0; seg < 400; seg++) begin
      joy0    ^= 6'($urandom_range(0, 63) & $urandom_range(0, 63));
      joy1    ^= 6'($urandom_range(0, 63) & $urandom_range(0, 63));
      buttons ^= 2'($urandom_range(0, 3) & $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) switches = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b0;
      end
      hold = $urandom_range(1, 12);
      repeat (hold) step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
